// File: rtl/dmem_if.sv
// Core-to-data-memory bus: access strobes and address/data from the core, read data and stall back.
interface dmem_if;
  logic        dmem_ena;
  logic        dmem_w;
  logic        dmem_r;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        cpu_ena;

  modport master (
    output dmem_ena, dmem_w, dmem_r, dmem_addr, dmem_wdata,
    input  dmem_rdata, cpu_ena
  );

  modport slave (
    input  dmem_ena, dmem_w, dmem_r, dmem_addr, dmem_wdata,
    output dmem_rdata, cpu_ena
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory stage: word RAM with registered reads plus LED/SW/CYC MMIO bank.
// Loads stall the core for one cycle via cpu_ena; stores complete in one cycle.
module dmem_bridge #(
  parameter logic [31:0] DMEM_BASE = 32'h1001_0000,
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] MMIO_BASE = 32'h1002_0000,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_if.slave            bus,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  typedef enum logic {IDLE, RESP} state_e;

  state_e state_q, state_d;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      ram_rd_q;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             err_q, err_d;
  logic             src_ram_q, src_ram_d;
  logic [31:0]      mmio_rd_q, mmio_rd_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          aligned, ram_hit, mmio_led, mmio_sw, mmio_cyc, bad;
  logic          rd_req, wr_req, both_req;
  logic          cpu_ena_c, issue_rd, do_wr, err_set;

  // Address and request decode
  always_comb begin
    offset   = bus.dmem_addr - DMEM_BASE;
    idx      = offset[AW+1:2];
    aligned  = (bus.dmem_addr[1:0] == 2'b00);
    ram_hit  = aligned && (bus.dmem_addr >= DMEM_BASE) && (offset < RAM_BYTES);
    mmio_led = (bus.dmem_addr == MMIO_BASE);
    mmio_sw  = (bus.dmem_addr == MMIO_BASE + 32'h4);
    mmio_cyc = (bus.dmem_addr == MMIO_BASE + 32'h8);
    bad      = !(ram_hit || mmio_led || mmio_sw || mmio_cyc);
    rd_req   = bus.dmem_ena &&  bus.dmem_r && !bus.dmem_w;
    wr_req   = bus.dmem_ena &&  bus.dmem_w && !bus.dmem_r;
    both_req = bus.dmem_ena &&  bus.dmem_w &&  bus.dmem_r;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: strobes seen in RESP belong to the load being committed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cpu_ena_c = 1'b1;
    issue_rd  = 1'b0;
    do_wr     = 1'b0;
    err_set   = 1'b0;
    if (state_q == IDLE) begin
      issue_rd  = rd_req;
      do_wr     = wr_req;
      cpu_ena_c = !rd_req;
      err_set   = both_req || ((rd_req || wr_req) && bad);
    end
  end

  // MMIO, error and read-capture next values
  always_comb begin
    led_d     = led_q;
    cyc_d     = cyc_q + 32'd1;
    err_d     = err_q | err_set;
    src_ram_d = src_ram_q;
    mmio_rd_d = mmio_rd_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    if (do_wr && mmio_led) led_d = bus.dmem_wdata[LED_W-1:0];
    if (do_wr && mmio_cyc) cyc_d = 32'd0;
    if (issue_rd) begin
      src_ram_d = ram_hit;
      if      (mmio_led) mmio_rd_d = 32'(led_q);
      else if (mmio_sw)  mmio_rd_d = 32'(sw_sync_q);
      else if (mmio_cyc) mmio_rd_d = cyc_q;
      else               mmio_rd_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      cyc_q     <= '0;
      err_q     <= 1'b0;
      src_ram_q <= 1'b0;
      mmio_rd_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      src_ram_q <= src_ram_d;
      mmio_rd_q <= mmio_rd_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // RAM array is not reset; its read port is registered
  always_ff @(posedge clk) begin
    if (do_wr && ram_hit)    mem[idx] <= bus.dmem_wdata;
    if (issue_rd && ram_hit) ram_rd_q <= mem[idx];
  end

  assign bus.dmem_rdata = src_ram_q ? ram_rd_q : mmio_rd_q;
  assign bus.cpu_ena    = cpu_ena_c;
  assign led_out        = led_q;
  assign err            = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge: RAM, MMIO, bad accesses, stall timing, reset.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        err;
  int          n_checks = 0;
  int          n_fail   = 0;

  dmem_if bus ();

  dmem_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.dmem_ena   = 1'b0;
    bus.dmem_w     = 1'b0;
    bus.dmem_r     = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Store: must not stall; completes on the next edge
  task automatic do_sw(input string tag, input logic [31:0] addr, input logic [31:0] data);
    bus.dmem_ena = 1'b1; bus.dmem_w = 1'b1; bus.dmem_r = 1'b0;
    bus.dmem_addr = addr; bus.dmem_wdata = data;
    #1 check({tag, "_nostall"}, 32'(bus.cpu_ena), 32'd1);
    @(posedge clk); #1;
    bus_idle();
  endtask

  // Load: stall in request cycle, data valid with cpu_ena=1 in the following cycle
  task automatic do_lw(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.dmem_ena = 1'b1; bus.dmem_w = 1'b0; bus.dmem_r = 1'b1;
    bus.dmem_addr = addr; bus.dmem_wdata = 32'h0;
    #1 check({tag, "_stall"}, 32'(bus.cpu_ena), 32'd0);
    @(posedge clk); #1;
    check({tag, "_resp_ena"}, 32'(bus.cpu_ena), 32'd1);
    check({tag, "_data"}, bus.dmem_rdata, exp);
    @(posedge clk); #1;
    bus_idle();
  endtask

  initial begin
    sw_in = 16'h0;
    rst   = 1'b1;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_rdata", bus.dmem_rdata, 32'h0);
    check("rst_cpu_ena", 32'(bus.cpu_ena), 32'd1);
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // RAM store then load
    do_sw("t1_sw", 32'h1001_0004, 32'hDEAD_BEEF);
    do_lw("t1_lw", 32'h1001_0004, 32'hDEAD_BEEF);
    check("t1_err", 32'(err), 32'h0);

    // First/last RAM word, back-to-back loads, then one past the end
    do_sw("t2_sw0", 32'h1001_0000, 32'h0123_4567);
    do_sw("t2_sw1", 32'h1001_1FFC, 32'h5555_AAAA);
    do_lw("t2_lw0", 32'h1001_0000, 32'h0123_4567);
    do_lw("t2_lw1", 32'h1001_1FFC, 32'h5555_AAAA);
    check("t2_err_clean", 32'(err), 32'h0);
    do_lw("t2_lw_end", 32'h1001_2000, 32'h0);
    check("t2_err_set", 32'(err), 32'h1);
    do_lw("t2_lw_after", 32'h1001_0004, 32'hDEAD_BEEF);
    check("t2_err_sticky", 32'(err), 32'h1);

    // Unmapped load, misaligned store, illegal r&w
    do_reset();
    check("t3_err_rst", 32'(err), 32'h0);
    do_lw("t3_lw_zero", 32'h0000_0000, 32'h0);
    check("t3_err_lw", 32'(err), 32'h1);
    do_reset();
    do_sw("t3_sw_mis", 32'h1001_0002, 32'hFFFF_FFFF);
    check("t3_err_sw", 32'(err), 32'h1);
    do_lw("t3_rb0", 32'h1001_0000, 32'h0123_4567);
    check("t3_err_hold", 32'(err), 32'h1);
    do_reset();
    bus.dmem_ena = 1'b1; bus.dmem_w = 1'b1; bus.dmem_r = 1'b1;
    bus.dmem_addr = 32'h1001_0004; bus.dmem_wdata = 32'h0;
    #1 check("t3_rw_nostall", 32'(bus.cpu_ena), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    check("t3_rw_err", 32'(err), 32'h1);
    do_lw("t3_rw_rb", 32'h1001_0004, 32'hDEAD_BEEF);

    // LED and switches
    do_reset();
    do_sw("t4_led", 32'h1002_0000, 32'h1234_ABCD);
    check("t4_led_out", 32'(led_out), 32'h0000_ABCD);
    do_lw("t4_led_rd", 32'h1002_0000, 32'h0000_ABCD);
    sw_in = 16'h00F0;
    repeat (3) @(posedge clk); #1;
    do_lw("t4_sw_rd", 32'h1002_0004, 32'h0000_00F0);
    do_sw("t4_sw_wr", 32'h1002_0004, 32'hFFFF_FFFF);
    check("t4_sw_wr_err", 32'(err), 32'h0);
    do_lw("t4_sw_rd2", 32'h1002_0004, 32'h0000_00F0);

    // Cycle counter clear, count and wrap
    do_sw("t5_cyc_clr", 32'h1002_0008, 32'h7777_7777);
    repeat (10) @(posedge clk); #1;
    do_lw("t5_cyc_rd", 32'h1002_0008, 32'h0000_000A);
    check("t5_err", 32'(err), 32'h0);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1 release dut.cyc_q;
    @(posedge clk); #1;
    check("t5_cyc_wrap", dut.cyc_q, 32'h0);
    @(posedge clk); #1;
    check("t5_cyc_after", dut.cyc_q, 32'h1);

    // Reset during RESP discards the pending read
    do_sw("t6_led", 32'h1002_0000, 32'h0000_5A5A);
    bus.dmem_ena = 1'b1; bus.dmem_w = 1'b0; bus.dmem_r = 1'b1;
    bus.dmem_addr = 32'h0000_0100; bus.dmem_wdata = 32'h0;
    @(posedge clk); #1;
    check("t6_pre_err", 32'(err), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    #1;
    check("t6_cpu_ena", 32'(bus.cpu_ena), 32'd1);
    check("t6_rdata", bus.dmem_rdata, 32'h0);
    check("t6_led", 32'(led_out), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    do_lw("t6_lw_after", 32'h1001_1FFC, 32'h5555_AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
Data-memory stage directly downstream of the single-cycle CPU core. It consumes the core's dmem_ena/dmem_w/dmem_r/dmem_addr/dmem_wdata, maps byte addresses onto a synchronous-read word RAM and a small MMIO register bank, and returns dmem_rdata. Because the RAM has registered reads, every load is stretched to 2 cycles by deasserting cpu_ena, which the top level wires to the core's ena input. The core's PC and register file hold while cpu_ena=0; that is a top-level integration requirement.

Parameters:
DMEM_BASE, 32'h1001_0000, byte address of RAM word 0.
DEPTH, 2048, RAM depth in 32-bit words; must be a power of 2.
MMIO_BASE, 32'h1002_0000, byte address of the MMIO bank: +0x0 LED, +0x4 SW, +0x8 CYC.
LED_W, 16, LED register width.
SW_W, 16, switch input width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
dmem_ena  in  1  access enable from the core.
dmem_w  in  1  write strobe.
dmem_r  in  1  read strobe.
dmem_addr  in  32  byte address.
dmem_wdata  in  32  write data.
sw_in  in  SW_W  asynchronous switch inputs.
dmem_rdata  out  32  read data to the core.
cpu_ena  out  1  core enable; 0 stalls the core.
led_out  out  LED_W  LED register.
err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, dmem_rdata=0, led_out=0, err=0, CYC=0, switch synchronizer flops=0. RAM contents are not reset.
- Request decode, valid only when dmem_ena=1:
  - rd_req = dmem_r & ~dmem_w.
  - wr_req = dmem_w & ~dmem_r.
  - dmem_r=dmem_w=1 is illegal: no action, no stall, err<=1.
- Region decode:
  - RAM hit: DMEM_BASE <= addr < DMEM_BASE+4*DEPTH; index = (addr-DMEM_BASE)>>2.
  - MMIO hit: addr is exactly MMIO_BASE+0x0, +0x4 or +0x8.
  - Anything else is "bad". addr[1:0]!=0 is also bad.
- State machine, 2 states:
  - IDLE:
    - wr_req completes in the same cycle, no stall: RAM[index]<=wdata, or the MMIO write.
    - rd_req: cpu_ena=0 combinationally this cycle; RAM/MMIO read is issued; next state RESP.
    - Otherwise cpu_ena=1.
  - RESP:
    - cpu_ena=1 and dmem_rdata holds the read value, so the core commits lw at the end of this cycle.
    - The core's strobes are still asserted in this cycle and are ignored (no re-stall, no re-write).
    - Next state IDLE.
- Load latency: exactly 2 cycles per lw, for RAM, MMIO and bad reads alike. Store latency: 1 cycle. Back-to-back loads each stall once.
- dmem_rdata is registered: updated on the IDLE->RESP edge and held otherwise. It is valid in RESP.
- Bad access:
  - Write is dropped.
  - Read returns 32'h0 with normal 2-cycle timing.
  - err<=1; err is sticky until rst.
- MMIO registers:
  - LED: write stores wdata[LED_W-1:0]; read returns it zero-extended.
  - SW: read-only; 2-flop synchronized sw_in, zero-extended; writes ignored with no error.
  - CYC: free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0. Any write clears it to 0 on that edge; clear has priority over increment. A read returns the value at the IDLE request cycle.
- rst during RESP: state->IDLE and the pending read is discarded. If rst and a write coincide on the same edge, reset wins for LED/CYC/err; the RAM write may occur.

Test Plan:
1. sw 0x1001_0004 <- 0xDEAD_BEEF, then lw 0x1001_0004 -> sw has no stall; lw has cpu_ena=0 for 1 cycle, then rdata=0xDEAD_BEEF in RESP with cpu_ena=1.
2. Back-to-back lw to 0x1001_0000 and 0x1001_1FFC (last word) -> cpu_ena pattern 0,1,0,1 with correct data each RESP; 0x1001_2000 -> rdata=0, err=1.
3. lw 0x0000_0000 and sw 0x1001_0002 (misaligned) -> rdata=0; the write is dropped (verify by read-back); err stays 1 until rst.
4. sw 0x1002_0000 <- 0x1234_ABCD -> led_out=0xABCD; lw 0x1002_0000 -> 0x0000_ABCD; sw_in=0x00F0 held 3 cycles, lw 0x1002_0004 -> 0x0000_00F0.
5. sw 0x1002_0008 (any data), 10 idle cycles, then lw 0x1002_0008 -> 0x0000_000A. Force CYC=0xFFFF_FFFF -> next cycle 0.
6. Assert rst during RESP of an lw -> next cycle state=IDLE, cpu_ena=1, dmem_rdata=0, led_out=0, err=0.
